// File: rtl/rabbit_frame_sender.sv
// Rabbit-link serial frame sender: latches a parallel word and shifts it
// out LSB-index first on SCLK/SDIO behind a frame_start strobe.
module rabbit_frame_sender #(
  parameter int WORD_BITS = 184,
  parameter int CLK_DIV   = 4
) (
  input  logic                 ten_MHz_ext,
  input  logic                 reset,
  input  logic                 load,
  input  logic [0:WORD_BITS-1] word_in,
  output logic                 busy,
  output logic                 done,
  output logic                 frame_start,
  output logic                 SCLK_out,
  output logic                 SDIO_out
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(WORD_BITS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_LOW,
    S_HIGH,
    S_FINISH
  } state_t;

  state_t               r_state;
  state_t               w_state_nx;
  logic [DW-1:0]        r_div;
  logic [DW-1:0]        w_div_nx;
  logic [BW-1:0]        r_bit;
  logic [BW-1:0]        w_bit_nx;
  logic [0:WORD_BITS-1] r_shift;
  logic [0:WORD_BITS-1] w_shift_nx;
  logic                 w_div_last;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_fs;
  logic                 r_sclk;
  logic                 r_sdio;

  assign w_div_last = (r_div == DIV_LAST);

  always_comb begin
    w_state_nx = r_state;
    w_div_nx   = r_div;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    unique case (r_state)
      S_IDLE: begin
        if (load) begin
          w_state_nx = S_START;
          w_div_nx   = '0;
          w_shift_nx = word_in;
        end
      end
      S_START: begin
        if (w_div_last) begin
          w_state_nx = S_LOW;
          w_div_nx   = '0;
          w_bit_nx   = '0;
        end else begin
          w_div_nx = r_div + DW'(1);
        end
      end
      S_LOW: begin
        if (w_div_last) begin
          w_state_nx = S_HIGH;
          w_div_nx   = '0;
        end else begin
          w_div_nx = r_div + DW'(1);
        end
      end
      S_HIGH: begin
        if (w_div_last) begin
          w_div_nx = '0;
          if (r_bit == BIT_LAST) begin
            w_state_nx = S_FINISH;
          end else begin
            // next bit moves into index 0, the SDIO source
            w_state_nx = S_LOW;
            w_bit_nx   = r_bit + BW'(1);
            w_shift_nx = r_shift << 1;
          end
        end else begin
          w_div_nx = r_div + DW'(1);
        end
      end
      S_FINISH: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // outputs are registered from the next-state decode
  always_ff @(posedge ten_MHz_ext or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fs    <= 1'b0;
      r_sclk  <= 1'b0;
      r_sdio  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_div   <= w_div_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
      r_busy  <= (w_state_nx == S_START) ||
                 (w_state_nx == S_LOW) ||
                 (w_state_nx == S_HIGH);
      r_done  <= (w_state_nx == S_FINISH);
      r_fs    <= (w_state_nx == S_START);
      r_sclk  <= (w_state_nx == S_HIGH);
      r_sdio  <= ((w_state_nx == S_LOW) ||
                  (w_state_nx == S_HIGH)) && w_shift_nx[0];
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign frame_start = r_fs;
  assign SCLK_out    = r_sclk;
  assign SDIO_out    = r_sdio;

endmodule

// File: tb/tb_rabbit_frame_sender.sv
// Bench for rabbit_frame_sender: three parameterisations driven with random
// frames and checked against a receiver-style reference model.
module tb_rabbit_frame_sender;

  localparam int NI  = 3;
  localparam int NEV = 32;
  localparam int WB[NI] = '{8, 184, 4};
  localparam int CD[NI] = '{2, 4, 1};

  logic         clk = 1'b0;
  logic         rst    [NI];
  logic         load   [NI];
  logic [0:183] word   [NI];
  logic         busy_v [NI];
  logic         done_v [NI];
  logic         fs_v   [NI];
  logic         sclk_v [NI];
  logic         sdio_v [NI];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // receiver / monitor state, written only by the monitor process
  logic [0:183] rx [NI];
  int nrx      [NI];
  int rises    [NI];
  int fs_cyc   [NI];
  int busy_cyc [NI];
  int stab_err [NI];
  int done_busy[NI];
  int n_fs     [NI];
  int n_bz     [NI];
  int n_done   [NI];
  int t_fs     [NI][NEV];
  int t_bz     [NI][NEV];
  int t_done   [NI][NEV];
  int r_done   [NI][NEV];
  bit p_fs     [NI];
  bit p_busy   [NI];
  bit p_sclk   [NI];
  bit p_sdio   [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rabbit_frame_sender #(.WORD_BITS(8), .CLK_DIV(2)) u_dut0 (
    .ten_MHz_ext (clk),
    .reset       (rst[0]),
    .load        (load[0]),
    .word_in     (word[0][0:7]),
    .busy        (busy_v[0]),
    .done        (done_v[0]),
    .frame_start (fs_v[0]),
    .SCLK_out    (sclk_v[0]),
    .SDIO_out    (sdio_v[0])
  );

  rabbit_frame_sender #(.WORD_BITS(184), .CLK_DIV(4)) u_dut1 (
    .ten_MHz_ext (clk),
    .reset       (rst[1]),
    .load        (load[1]),
    .word_in     (word[1]),
    .busy        (busy_v[1]),
    .done        (done_v[1]),
    .frame_start (fs_v[1]),
    .SCLK_out    (sclk_v[1]),
    .SDIO_out    (sdio_v[1])
  );

  rabbit_frame_sender #(.WORD_BITS(4), .CLK_DIV(1)) u_dut2 (
    .ten_MHz_ext (clk),
    .reset       (rst[2]),
    .load        (load[2]),
    .word_in     (word[2][0:3]),
    .busy        (busy_v[2]),
    .done        (done_v[2]),
    .frame_start (fs_v[2]),
    .SCLK_out    (sclk_v[2]),
    .SDIO_out    (sdio_v[2])
  );

  initial begin
    for (int g = 0; g < NI; g++) begin
      rx[g] = '0;
      nrx[g] = 0; rises[g] = 0; fs_cyc[g] = 0; busy_cyc[g] = 0;
      stab_err[g] = 0; done_busy[g] = 0;
      n_fs[g] = 0; n_bz[g] = 0; n_done[g] = 0;
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (fs_v[g] && !p_fs[g]) begin
        if (n_fs[g] < NEV) t_fs[g][n_fs[g]] = cyc;
        n_fs[g]++;
        rx[g] = '0;
        nrx[g] = 0;
      end
      if (fs_v[g]) fs_cyc[g]++;
      if (busy_v[g]) busy_cyc[g]++;
      if (busy_v[g] && !p_busy[g]) begin
        if (n_bz[g] < NEV) t_bz[g][n_bz[g]] = cyc;
        n_bz[g]++;
      end
      if (sclk_v[g] && !p_sclk[g]) begin
        if (nrx[g] < 184) rx[g][nrx[g]] = sdio_v[g];
        nrx[g]++;
        rises[g]++;
      end
      if ((sdio_v[g] != p_sdio[g]) && sclk_v[g]) stab_err[g]++;
      if (done_v[g]) begin
        if (n_done[g] < NEV) begin
          t_done[g][n_done[g]] = cyc;
          r_done[g][n_done[g]] = rises[g];
        end
        n_done[g]++;
        if (busy_v[g]) done_busy[g]++;
      end
      p_fs[g]   = fs_v[g];
      p_busy[g] = busy_v[g];
      p_sclk[g] = sclk_v[g];
      p_sdio[g] = sdio_v[g];
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [0:183] rand_word();
    logic [0:183] w;
    for (int i = 0; i < 184; i++) w[i] = 1'($urandom_range(0, 1));
    return w;
  endfunction

  function automatic logic [0:183] expect_bits(input int g,
                                               input logic [0:183] w);
    logic [0:183] e;
    e = '0;
    for (int i = 0; i < WB[g]; i++) e[i] = w[i];
    return e;
  endfunction

  task automatic run_frame(input int g, input logic [0:183] w,
                           input bit mid);
    int acc, b_r, b_fs, b_bz, nd, k, W, C, td, flen;
    W = WB[g];
    C = CD[g];
    flen = C * (1 + 2 * W);
    word[g] = w;
    load[g] = 1'b1;
    step();
    acc = cyc;
    load[g] = 1'b0;
    b_r  = rises[g];
    b_fs = fs_cyc[g];
    b_bz = busy_cyc[g];
    nd   = n_done[g];
    k = 0;
    while (n_done[g] == nd && k < flen + 10) begin
      if (mid && k == C * 10) begin
        word[g] = ~w;
        load[g] = 1'b1;
      end else begin
        load[g] = 1'b0;
      end
      step();
      k++;
    end
    load[g] = 1'b0;
    if (n_done[g] == nd || nd >= NEV) begin
      chk("done_timeout", 0, 1);
      return;
    end
    td = t_done[g][nd];
    chk("done_cycle", td - acc + 1, flen + 1);
    chk("frame_len", td - t_fs[g][n_fs[g] - 1], flen);
    chk("sclk_rises", rises[g] - b_r, W);
    chk("fs_width", fs_cyc[g] - b_fs, C);
    chk("busy_len", busy_cyc[g] - b_bz, flen);
    chk("rx_bits", int'(rx[g] === expect_bits(g, w)), 1);
  endtask

  task automatic reset_mid();
    logic [0:183] w;
    int b_r, nd, k;
    w = rand_word();
    word[1] = w;
    load[1] = 1'b1;
    step();
    load[1] = 1'b0;
    b_r = rises[1];
    nd  = n_done[1];
    k = 0;
    while (rises[1] - b_r < 50 && k < 2000) begin
      step();
      k++;
    end
    chk("bit50_reached", rises[1] - b_r, 50);
    chk("busy_pre_rst", int'(busy_v[1]), 1);
    @(negedge clk);
    #2 rst[1] = 1'b1;
    #1 chk("rst_async_outs",
           int'({busy_v[1], done_v[1], fs_v[1], sclk_v[1], sdio_v[1]}), 0);
    repeat (2) step();
    @(negedge clk);
    #2 rst[1] = 1'b0;
    repeat (10) step();
    chk("no_done_after_rst", n_done[1] - nd, 0);
    chk("idle_after_rst", int'({busy_v[1], sclk_v[1]}), 0);
    run_frame(1, rand_word(), 1'b0);
  endtask

  task automatic continuous();
    int b_fs, b_bz, b_d, b_r, k;
    logic [0:183] w;
    w = rand_word();
    b_fs = n_fs[2];
    b_bz = n_bz[2];
    b_d  = n_done[2];
    b_r  = rises[2];
    word[2] = w;
    load[2] = 1'b1;
    k = 0;
    while (n_done[2] - b_d < 4 && k < 100) begin
      step();
      k++;
    end
    load[2] = 1'b0;
    repeat (20) step();
    if (n_done[2] - b_d < 4 || b_d + 4 >= NEV) begin
      chk("cont_timeout", 0, 1);
      return;
    end
    for (int j = 0; j < 4; j++) begin
      chk("cont_len", t_done[2][b_d + j] - t_fs[2][b_fs + j], 9);
      chk("cont_rises", r_done[2][b_d + j] -
          ((j == 0) ? b_r : r_done[2][b_d + j - 1]), 4);
      chk("cont_busy_fs", t_bz[2][b_bz + j] - t_fs[2][b_fs + j], 0);
      if (j < 3)
        chk("cont_gap", t_bz[2][b_bz + j + 1] - t_done[2][b_d + j], 2);
    end
    chk("cont_frames", n_done[2] - b_d, 4);
    chk("cont_rx", int'(rx[2] === expect_bits(2, w)), 1);
  endtask

  initial begin
    logic [0:183] w;
    for (int g = 0; g < NI; g++) begin
      rst[g]  = 1'b1;
      load[g] = 1'b0;
      word[g] = '0;
    end
    repeat (3) step();
    for (int g = 0; g < NI; g++)
      chk("reset_outs",
          int'({busy_v[g], done_v[g], fs_v[g], sclk_v[g], sdio_v[g]}), 0);
    for (int g = 0; g < NI; g++) rst[g] = 1'b0;
    repeat (2) step();

    w = '0;
    w[0:7] = 8'b1011_0010;
    run_frame(0, w, 1'b0);
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 3)) step();
      run_frame(0, rand_word(), 1'b0);
    end

    for (int i = 0; i < 184; i++) w[i] = (i % 2 == 0);
    run_frame(1, w, 1'b0);
    run_frame(1, rand_word(), 1'b0);
    run_frame(1, rand_word(), 1'b1);
    run_frame(0, rand_word(), 1'b1);
    reset_mid();

    continuous();
    run_frame(2, rand_word(), 1'b0);

    for (int g = 0; g < NI; g++) begin
      chk("sdio_stable", stab_err[g], 0);
      chk("done_busy_low", done_busy[g], 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
